// File: rtl/qq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : qq_arbiter
// Description : Round-robin arbiter/sequencer sharing one qq_top priority
//               queue among N requesters. Grants one request at a time,
//               pre-checks it against the queue full/empty flags, issues a
//               single-cycle command pulse, waits for the queue ready
//               handshake (with timeout) and returns status plus the old
//               head key to the winning requester.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               req/op/key          - per-requester request, opcode, key
//               ack/rsp_*           - one-cycle response to the winner
//               q_enq/q_deq/q_repl  - command pulses to the queue
//               q_key               - key driven to the queue
//               q_lt_o              - current queue head
//               q_full/q_empty/q_rdy- queue status
//               busy                - operation in flight
// Revision    : 1.0 - initial release
// ============================================================================
module qq_arbiter #(
    parameter int W   = 8,
    parameter int N   = 4,
    parameter int TMO = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [2*N-1:0]       op,
    input  logic [N*W-1:0]       key,
    output logic [N-1:0]         ack,
    output logic                 rsp_valid,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [W-1:0]         rsp_key,
    output logic [1:0]           rsp_err,
    output logic                 q_enq,
    output logic                 q_deq,
    output logic                 q_repl,
    output logic [W-1:0]         q_key,
    input  logic [W-1:0]         q_lt_o,
    input  logic                 q_full,
    input  logic                 q_empty,
    input  logic                 q_rdy,
    output logic                 busy
);

    localparam int c_IDW = $clog2(N);
    localparam int c_OPW = $clog2(2 * N);
    localparam int c_KW  = $clog2(N * W);
    localparam int c_CW  = (TMO > 1) ? $clog2(TMO) : 1;

    localparam logic [c_CW-1:0]  c_TMO_LAST = c_CW'(TMO - 1);
    localparam logic [c_IDW-1:0] c_ID_LAST  = c_IDW'(N - 1);
    localparam logic [N-1:0]     c_ACK_ONE  = {{(N-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_OP_ENQ  = 2'b01;
    localparam logic [1:0] c_OP_DEQ  = 2'b10;
    localparam logic [1:0] c_OP_REPL = 2'b11;

    localparam logic [1:0] c_ERR_OK    = 2'b00;
    localparam logic [1:0] c_ERR_FULL  = 2'b01;
    localparam logic [1:0] c_ERR_EMPTY = 2'b10;
    localparam logic [1:0] c_ERR_BAD   = 2'b11;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ISSUE   = 3'd1;
    localparam logic [2:0] c_ST_WAIT_LO = 3'd2;
    localparam logic [2:0] c_ST_WAIT_HI = 3'd3;
    localparam logic [2:0] c_ST_RESP    = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [c_IDW-1:0] r_rr_ptr;
    logic [c_IDW-1:0] r_id;
    logic [1:0]       r_op;
    logic [W-1:0]     r_key;
    logic [W-1:0]     r_rsp_key;
    logic [1:0]       r_err;
    logic             r_lo_cnt;
    logic [c_CW-1:0]  r_hi_cnt;

    int               w_j;
    logic             w_found;
    logic [c_IDW-1:0] w_win;
    logic [1:0]       w_op;
    logic [W-1:0]     w_key;
    logic [c_IDW-1:0] w_ptr_nxt;
    logic [1:0]       w_chk;
    logic             w_grant;

    // Round-robin search: first asserted request at or after r_rr_ptr, wrapping.
    always_comb begin
        w_j     = 0;
        w_found = 1'b0;
        w_win   = '0;
        w_op    = 2'b00;
        w_key   = '0;
        for (int i = 0; i < N; i++) begin
            w_j = int'(r_rr_ptr) + i;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!w_found && req[c_IDW'(w_j)]) begin
                w_found = 1'b1;
                w_win   = c_IDW'(w_j);
                w_op    = op[c_OPW'(2 * w_j) +: 2];
                w_key   = key[c_KW'(W * w_j) +: W];
            end
        end
    end

    assign w_ptr_nxt = (w_win == c_ID_LAST) ? '0 : w_win + 1'b1;
    assign w_grant   = q_rdy && w_found;

    // Legality pre-check against the flags seen in the grant cycle.
    always_comb begin
        w_chk = c_ERR_OK;
        case (w_op)
            c_OP_ENQ:            w_chk = q_full  ? c_ERR_FULL  : c_ERR_OK;
            c_OP_DEQ, c_OP_REPL: w_chk = q_empty ? c_ERR_EMPTY : c_ERR_OK;
            default:             w_chk = c_ERR_BAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = (w_chk != c_ERR_OK) ? c_ST_RESP : c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: w_state_nxt = c_ST_WAIT_LO;
            c_ST_WAIT_LO: begin
                // A queue that never drops ready is taken as having finished.
                if (!q_rdy) begin
                    w_state_nxt = c_ST_WAIT_HI;
                end else if (r_lo_cnt) begin
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_WAIT_HI: begin
                if (q_rdy || (r_hi_cnt == c_TMO_LAST)) begin
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_RESP: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_id      <= '0;
            r_op      <= 2'b00;
            r_key     <= '0;
            r_rsp_key <= '0;
            r_err     <= c_ERR_OK;
            r_lo_cnt  <= 1'b0;
            r_hi_cnt  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant) begin
                        r_id      <= w_win;
                        r_op      <= w_op;
                        r_key     <= w_key;
                        r_rr_ptr  <= w_ptr_nxt;
                        r_err     <= w_chk;
                        r_rsp_key <= '0;
                    end
                end
                c_ST_ISSUE: begin
                    r_rsp_key <= (r_op == c_OP_ENQ) ? '0 : q_lt_o;
                    r_lo_cnt  <= 1'b0;
                end
                c_ST_WAIT_LO: begin
                    r_lo_cnt <= 1'b1;
                    r_hi_cnt <= '0;
                end
                c_ST_WAIT_HI: begin
                    if (!q_rdy) begin
                        if (r_hi_cnt == c_TMO_LAST) begin
                            r_err <= c_ERR_BAD;
                        end else begin
                            r_hi_cnt <= r_hi_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != c_ST_IDLE);
    assign q_enq     = (r_state == c_ST_ISSUE) && (r_op == c_OP_ENQ);
    assign q_deq     = (r_state == c_ST_ISSUE) && (r_op == c_OP_DEQ);
    assign q_repl    = (r_state == c_ST_ISSUE) && (r_op == c_OP_REPL);
    assign q_key     = r_key;
    assign rsp_valid = (r_state == c_ST_RESP);
    assign ack       = rsp_valid ? (c_ACK_ONE << r_id) : '0;
    assign rsp_id    = r_id;
    assign rsp_key   = r_rsp_key;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_qq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_qq_arbiter
// Description : Self-checking bench for qq_arbiter. A behavioural priority
//               queue (sorted list, min at head) stands in for qq_top, and a
//               transaction-level model predicts winner, status, head key,
//               command pulse and response latency for every request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qq_arbiter;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int TMO = 64;
    localparam int CAP = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req;
    logic [2*N-1:0]       op;
    logic [N*W-1:0]       key;
    logic [N-1:0]         ack;
    logic                 rsp_valid;
    logic [$clog2(N)-1:0] rsp_id;
    logic [W-1:0]         rsp_key;
    logic [1:0]           rsp_err;
    logic                 q_enq, q_deq, q_repl;
    logic [W-1:0]         q_key;
    logic [W-1:0]         q_lt_o;
    logic                 q_full, q_empty, q_rdy;
    logic                 busy;

    qq_arbiter #(.W(W), .N(N), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .key(key),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_key(rsp_key), .rsp_err(rsp_err),
        .q_enq(q_enq), .q_deq(q_deq), .q_repl(q_repl), .q_key(q_key),
        .q_lt_o(q_lt_o), .q_full(q_full), .q_empty(q_empty), .q_rdy(q_rdy),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Queue stand-in state
    int         qs[$];
    int         rdy_cnt      = 0;
    int         lat_force    = -1;
    int         last_lat     = 0;
    logic       force_full   = 1'b0;
    logic       force_empty  = 1'b0;
    int         pulses       = 0;
    logic [2:0] last_cmd     = 3'b000;
    logic [W-1:0] last_cmd_key = '0;

    // Requester-side model
    logic       p_req[N];
    logic [1:0] p_op[N];
    logic [W-1:0] p_key[N];
    int         waitg[N];
    int         m_ptr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic update_stub();
        q_lt_o  = (qs.size() > 0) ? W'(qs[0]) : '0;
        q_full  = (qs.size() >= CAP) || force_full;
        q_empty = (qs.size() == 0) || force_empty;
        q_rdy   = (rdy_cnt == 0);
    endtask

    // One clock: sample commands mid-cycle, let the queue react just after the edge.
    task automatic tick();
        logic [2:0]   c;
        logic [W-1:0] k;
        int           tmp;
        @(negedge clk);
        c = {q_enq, q_deq, q_repl};
        k = q_key;
        if (c != 3'b000) check("cmd_onehot", $countones(c), 1);
        @(posedge clk);
        #1;
        if (rdy_cnt > 0) rdy_cnt--;
        if (c == 3'b100 || c == 3'b010 || c == 3'b001) begin
            pulses++;
            last_cmd     = c;
            last_cmd_key = k;
            if ((c[1] || c[0]) && qs.size() > 0) tmp = qs.pop_front();
            if (c[2] || c[0]) begin
                qs.push_back(int'(k));
                qs.sort();
            end
            last_lat = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 4));
            rdy_cnt  = last_lat;
        end
        update_stub();
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req[i]         = p_req[i];
            op[2*i +: 2]   = p_op[i];
            key[W*i +: W]  = p_key[i];
        end
    endtask

    task automatic arm(input int i, input logic [1:0] o, input logic [W-1:0] k);
        p_req[i] = 1'b1;
        p_op[i]  = o;
        p_key[i] = k;
        waitg[i] = 0;
    endtask

    function automatic logic [1:0] rand_op();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 2'b00;
        if (r <= 4) return 2'b01;
        if (r <= 7) return 2'b10;
        return 2'b11;
    endfunction

    // Present pending requests, predict the next grant and check its response.
    task automatic serve_one(input string tag, output int obs_id, output int obs_key);
        int win, j, n, p0, guard, exp_n, ekey;
        logic [1:0] eop, eerr;
        logic [2:0] ecmd;
        logic [N-1:0] eack;
        drive_inputs();
        guard = 0;
        while ((busy || !q_rdy) && guard < 300) begin
            tick();
            guard++;
        end
        win = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (m_ptr + i) % N;
            if (p_req[j]) win = j;
        end
        eop = p_op[win];
        case (eop)
            2'b01:        eerr = q_full  ? 2'b01 : 2'b00;
            2'b10, 2'b11: eerr = q_empty ? 2'b10 : 2'b00;
            default:      eerr = 2'b11;
        endcase
        ekey  = (eerr == 2'b00 && eop != 2'b01) ? qs[0] : 0;
        ecmd  = (eop == 2'b01) ? 3'b100 : (eop == 2'b10) ? 3'b010 : 3'b001;
        m_ptr = (win + 1) % N;
        p0    = pulses;
        n     = 0;
        do begin
            tick();
            n++;
        end while (!rsp_valid && n < 300);
        if (eerr != 2'b00) exp_n = 1;
        else if (last_lat == 0) exp_n = 4;
        else if (last_lat <= TMO) exp_n = 3 + last_lat;
        else begin
            exp_n = 3 + TMO;
            eerr  = 2'b11;
        end
        eack = '0;
        eack[win] = 1'b1;
        check({tag, "_valid"},   rsp_valid, 1);
        check({tag, "_latency"}, n, exp_n);
        check({tag, "_id"},      rsp_id, win);
        check({tag, "_ack"},     ack, eack);
        check({tag, "_err"},     rsp_err, eerr);
        check({tag, "_key"},     rsp_key, ekey);
        check({tag, "_pulses"},  pulses - p0, (p_op[win] != 2'b00 && (eerr == 2'b00 || exp_n == 3 + TMO)) ? 1 : 0);
        if (pulses != p0) begin
            check({tag, "_cmd"},   last_cmd, ecmd);
            check({tag, "_q_key"}, last_cmd_key, p_key[win]);
        end
        check({tag, "_fair"}, (waitg[win] < N) ? 1 : 0, 1);
        for (int i = 0; i < N; i++) if (p_req[i] && i != win) waitg[i]++;
        waitg[win] = 0;
        obs_id  = int'(rsp_id);
        obs_key = int'(rsp_key);
        p_req[win] = 1'b0;
        drive_inputs();
    endtask

    initial begin
        int id, k, any;
        for (int i = 0; i < N; i++) begin
            p_req[i] = 1'b0; p_op[i] = 2'b00; p_key[i] = '0; waitg[i] = 0;
        end
        rst = 1'b1;
        drive_inputs();
        update_stub();
        repeat (3) tick();
        check("rst_busy",  busy, 0);
        check("rst_ack",   ack, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_cmd",   {q_enq, q_deq, q_repl}, 0);
        check("rst_qkey",  q_key, 0);
        check("rst_err",   rsp_err, 0);
        rst = 1'b0;
        tick();

        // Single enqueue into an empty queue
        arm(0, 2'b01, 8'd5);
        serve_one("enq5", id, k);
        check("enq5_rsp_key", k, 0);

        // Fresh pointer, four simultaneous enqueues served in index order
        rst = 1'b1; tick(); rst = 1'b0; m_ptr = 0; tick();
        arm(0, 2'b01, 8'd10); arm(1, 2'b01, 8'd3); arm(2, 2'b01, 8'd20); arm(3, 2'b01, 8'd2);
        for (int i = 0; i < N; i++) begin
            serve_one("rr4", id, k);
            check("rr4_order", id, i);
        end

        // Dequeue then replace from the same requester
        arm(2, 2'b10, 8'd0);
        serve_one("deq", id, k);
        check("deq_head", k, 2);
        arm(2, 2'b11, 8'd30);
        serve_one("repl", id, k);
        check("repl_head", k, 3);

        // Rejections: empty, full, bad opcode
        force_empty = 1'b1; update_stub();
        arm(1, 2'b10, 8'd0);
        serve_one("rej_empty", id, k);
        force_empty = 1'b0; force_full = 1'b1; update_stub();
        arm(3, 2'b01, 8'd9);
        serve_one("rej_full", id, k);
        force_full = 1'b0; update_stub();
        arm(0, 2'b00, 8'd77);
        serve_one("rej_bad", id, k);

        // Ready held low past the timeout
        lat_force = 70;
        arm(0, 2'b01, 8'd7);
        serve_one("tmo", id, k);
        tick();
        check("tmo_idle", busy, 0);

        // Reset while waiting for ready; queued requests then proceed from pointer 0
        arm(2, 2'b01, 8'd40);
        drive_inputs();
        k = 0;
        while ((busy || !q_rdy) && k < 300) begin tick(); k++; end
        repeat (12) tick();
        check("wait_hi_busy", busy, 1);
        rst = 1'b1;
        p_req[2] = 1'b0;
        arm(1, 2'b10, 8'd0);
        arm(3, 2'b01, 8'd50);
        drive_inputs();
        tick();
        check("midrst_busy",  busy, 0);
        check("midrst_ack",   ack, 0);
        check("midrst_valid", rsp_valid, 0);
        rst = 1'b0; m_ptr = 0; lat_force = -1;
        serve_one("post_rst_a", id, k);
        check("post_rst_first", id, 1);
        serve_one("post_rst_b", id, k);
        check("post_rst_second", id, 3);

        // Randomized traffic
        for (int i = 0; i < N; i++) arm(i, rand_op(), W'($urandom_range(0, 255)));
        for (int t = 0; t < 150; t++) begin
            serve_one("rnd", id, k);
            if ($urandom_range(0, 3) != 0) arm(id, rand_op(), W'($urandom_range(0, 255)));
            any = 0;
            for (int i = 0; i < N; i++) if (p_req[i]) any = 1;
            if (any == 0) arm(int'($urandom_range(0, N - 1)), rand_op(), W'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
